// File: rtl/tanh_backward_if.sv
// Handshake bundle for tanh_backward: (y_in, g_in) request side and dx_out result side.
// The master modport is the environment; the slave modport is the tanh_backward block.
interface tanh_backward_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] y_in;
    logic [31:0] g_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dx_out;
    logic        sat_flag;

    modport master (
        output in_valid, y_in, g_in, out_ready,
        input  in_ready, out_valid, dx_out, sat_flag
    );

    modport slave (
        input  in_valid, y_in, g_in, out_ready,
        output in_ready, out_valid, dx_out, sat_flag
    );
endinterface

// File: rtl/tanh_backward.sv
// Backward pass of tanh: dx = g * (1 - yn^2), yn = y / GAIN with saturation codes and clamping.
// Define TANH_BWD_BACK2BACK_EN to let HOLD retire a result and accept a new pair on one edge.
module tanh_backward #(
    parameter int SCALE = 100_000_000,
    parameter int GAIN  = 21
) (
    input  logic            clk,
    input  logic            rst,
    tanh_backward_if.slave  bus,
    output logic            busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        NORM = 3'd1,
        SQR  = 3'd2,
        MUL  = 3'd3,
        HOLD = 3'd4
    } state_t;

    localparam logic signed [31:0] SCALE_N = 32'(SCALE);
    localparam logic signed [31:0] GAIN_N  = 32'(GAIN);
    localparam logic signed [63:0] SCALE_W = 64'(SCALE);
    localparam logic [31:0]        CODE_POS = 32'h7FFF_FFFF;
    localparam logic [31:0]        CODE_NEG = 32'h8000_0000;

    state_t             state_q, state_d;
    logic signed [31:0] y_q, y_d;
    logic signed [31:0] g_q, g_d;
    logic signed [31:0] yn_q, yn_d;
    logic signed [31:0] d_q, d_d;
    logic signed [31:0] dx_q, dx_d;
    logic               sat_r_q, sat_r_d;
    logic               sat_q, sat_d;
    logic               out_valid_q, out_valid_d;

    logic               in_ready;
    logic               accept;
    logic signed [31:0] y_div;
    logic signed [63:0] yn_w;
    logic signed [63:0] g_w;
    logic signed [63:0] d_w;

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (state_q == IDLE) begin
                in_ready = 1'b1;
            end
`ifdef TANH_BWD_BACK2BACK_EN
            else if (state_q == HOLD) begin
                in_ready = bus.out_ready;
            end
`endif
        end
    end

    assign accept = bus.in_valid && in_ready;
    // Signed division truncates toward zero, matching the required rounding.
    assign y_div  = y_q / GAIN_N;
    assign yn_w   = {{32{yn_q[31]}}, yn_q};
    assign g_w    = {{32{g_q[31]}}, g_q};
    assign d_w    = {{32{d_q[31]}}, d_q};

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        g_d         = g_q;
        yn_d        = yn_q;
        d_d         = d_q;
        dx_d        = dx_q;
        sat_r_d     = sat_r_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    y_d     = bus.y_in;
                    g_d     = bus.g_in;
                    state_d = NORM;
                end
            end
            NORM: begin
                sat_r_d = 1'b1;
                if (y_q == CODE_POS) begin
                    yn_d = SCALE_N;
                end else if (y_q == CODE_NEG) begin
                    yn_d = -SCALE_N;
                end else if (y_div > SCALE_N) begin
                    yn_d = SCALE_N;
                end else if (y_div < -SCALE_N) begin
                    yn_d = -SCALE_N;
                end else begin
                    yn_d    = y_div;
                    sat_r_d = 1'b0;
                end
                state_d = SQR;
            end
            SQR: begin
                d_d     = 32'(SCALE_W - (yn_w * yn_w) / SCALE_W);
                state_d = MUL;
            end
            MUL: begin
                dx_d        = 32'((g_w * d_w) / SCALE_W);
                sat_d       = sat_r_q;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                    // accept can only be true here when back-to-back mode opens in_ready.
                    if (accept) begin
                        y_d     = bus.y_in;
                        g_d     = bus.g_in;
                        state_d = NORM;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            y_q         <= '0;
            g_q         <= '0;
            yn_q        <= '0;
            d_q         <= '0;
            dx_q        <= '0;
            sat_r_q     <= 1'b0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            g_q         <= g_d;
            yn_q        <= yn_d;
            d_q         <= d_d;
            dx_q        <= dx_d;
            sat_r_q     <= sat_r_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.dx_out    = dx_q;
    assign bus.sat_flag  = sat_q;
    assign busy          = (state_q != IDLE);

endmodule
